// File: rtl/reset_seq_ctrl.sv
// Staged reset sequencer: PLL lock stretch, peripheral release, then CPU release.
// Optional button debounce is built only when RESET_SEQ_DEBOUNCE_EN is defined.
module reset_seq_ctrl #(
    parameter int unsigned STRETCH_CYCLES  = 255,
    parameter int unsigned STAGE_GAP       = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       btn_reset,
    output logic       periph_reset,
    output logic       cpu_reset,
    output logic       seq_done,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [1:0] {StWaitLock, StStretch, StPeriph, StRun} state_e;

    localparam logic [15:0] StretchLast = 16'(STRETCH_CYCLES - 1);
    localparam logic [15:0] GapLast     = 16'(STAGE_GAP - 1);

    logic lock_meta_q, lock_s_q, btn_meta_q, btn_s_q;
    logic btn_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            btn_meta_q  <= 1'b0;
            btn_s_q     <= 1'b0;
        end else begin
            lock_meta_q <= pll_locked;
            lock_s_q    <= lock_meta_q;
            btn_meta_q  <= btn_reset;
            btn_s_q     <= btn_meta_q;
        end
    end

`ifdef RESET_SEQ_DEBOUNCE_EN
    localparam logic [15:0] DbLast = 16'(DEBOUNCE_CYCLES - 1);

    logic [15:0] db_cnt_q, db_cnt_d;
    logic        btn_req_q, btn_req_d;

    // Counter runs only while the synchronized level disagrees with the accepted one.
    always_comb begin
        db_cnt_d  = '0;
        btn_req_d = btn_req_q;
        if (btn_s_q != btn_req_q) begin
            if (db_cnt_q == DbLast) begin
                btn_req_d = btn_s_q;
            end else begin
                db_cnt_d = db_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt_q  <= '0;
            btn_req_q <= 1'b0;
        end else begin
            db_cnt_q  <= db_cnt_d;
            btn_req_q <= btn_req_d;
        end
    end

    assign btn_req = btn_req_q;
`else
    assign btn_req = btn_s_q;
`endif

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        periph_q, periph_d;
    logic        cpu_q, cpu_d;
    logic        done_q, done_d;
    logic [7:0]  loss_q, loss_d;
    logic        abort;

    assign abort = !lock_s_q || btn_req;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        periph_d = periph_q;
        cpu_d    = cpu_q;
        done_d   = done_q;
        loss_d   = loss_q;
        if (state_q != StWaitLock && abort) begin
            // Abort outranks the terminal-count transitions.
            state_d  = StWaitLock;
            cnt_d    = '0;
            periph_d = 1'b1;
            cpu_d    = 1'b1;
            done_d   = 1'b0;
            if (state_q == StRun && !lock_s_q && loss_q != 8'hFF) begin
                loss_d = loss_q + 8'd1;
            end
        end else begin
            unique case (state_q)
                StWaitLock: begin
                    cnt_d = '0;
                    if (lock_s_q && !btn_req) begin
                        state_d = StStretch;
                    end
                end
                StStretch: begin
                    if (cnt_q == StretchLast) begin
                        state_d  = StPeriph;
                        cnt_d    = '0;
                        periph_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StPeriph: begin
                    if (cnt_q == GapLast) begin
                        state_d = StRun;
                        cnt_d   = '0;
                        cpu_d   = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StRun: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = StWaitLock;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StWaitLock;
            cnt_q    <= '0;
            periph_q <= 1'b1;
            cpu_q    <= 1'b1;
            done_q   <= 1'b0;
            loss_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            periph_q <= periph_d;
            cpu_q    <= cpu_d;
            done_q   <= done_d;
            loss_q   <= loss_d;
        end
    end

    assign periph_reset  = periph_q;
    assign cpu_reset     = cpu_q;
    assign seq_done      = done_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Self-checking bench for reset_seq_ctrl: expected edges/values are queued when
// stimulus is applied and popped when the DUT reacts.
module tb_reset_seq_ctrl;

    localparam int unsigned STRETCH = 8;
    localparam int unsigned GAP     = 4;
    localparam int unsigned DEB     = 16;

    logic       clk;
    logic       reset;
    logic       pll_locked;
    logic       btn_reset;
    logic       periph_reset;
    logic       cpu_reset;
    logic       seq_done;
    logic [7:0] lock_loss_cnt;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    typedef struct {
        string name;
        int    val;
    } exp_t;

    exp_t exp_q[$];

    reset_seq_ctrl #(
        .STRETCH_CYCLES (STRETCH),
        .STAGE_GAP      (GAP),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pll_locked   (pll_locked),
        .btn_reset    (btn_reset),
        .periph_reset (periph_reset),
        .cpu_reset    (cpu_reset),
        .seq_done     (seq_done),
        .lock_loss_cnt(lock_loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    // Output ordering must hold at every settled point.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if ((cpu_reset === 1'b0 && periph_reset !== 1'b0) || seq_done !== ~cpu_reset) begin
                errors++;
                $display("FAIL invariant: periph=%b cpu=%b seq_done=%b at edge %0d",
                         periph_reset, cpu_reset, seq_done, edge_n);
            end
        end
    end

    function automatic void push_exp(input string n, input int v);
        exp_t e;
        e.name = n;
        e.val  = v;
        exp_q.push_back(e);
    endfunction

    function automatic exp_t pop_exp();
        exp_t e;
        if (exp_q.size() == 0) begin
            e.name = "empty_queue";
            e.val  = -99;
        end else begin
            e = exp_q.pop_front();
        end
        return e;
    endfunction

    function automatic logic sel(input int which);
        case (which)
            0:       return periph_reset;
            1:       return cpu_reset;
            default: return seq_done;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    // Returns the edge index at which the selected output first reads val, or -1.
    task automatic wait_for(input int which, input logic val, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (sel(which) === val) begin
                at = edge_n;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        pll_locked = 1'b0;
        btn_reset  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (periph_reset !== 1'b1) begin
            errors++;
            $display("FAIL rst_periph: got %b want 1", periph_reset);
        end
        checks++;
        if (cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL rst_cpu: got %b want 1", cpu_reset);
        end
        checks++;
        if (seq_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_seq_done: got %b want 0", seq_done);
        end
        checks++;
        if (lock_loss_cnt !== 8'd0) begin
            errors++;
            $display("FAIL rst_loss_cnt: got %0d want 0", lock_loss_cnt);
        end
    endtask

    // Lock already high when reset drops: edge 0 is the first edge after release.
    task automatic test_power_up();
        int   at;
        exp_t e;
        pll_locked = 1'b1;
        step();
        reset  = 1'b0;
        edge_n = -1;
        push_exp("pu_periph_fall", 1 + 1 + STRETCH);
        push_exp("pu_cpu_fall", 1 + 1 + STRETCH + GAP);
        push_exp("pu_seq_done_rise", 1 + 1 + STRETCH + GAP);
        wait_for(0, 1'b0, 40, at);
        e = pop_exp();
        checks++;
        if (at !== e.val) begin
            errors++;
            $display("FAIL %s: got edge %0d want edge %0d", e.name, at, e.val);
        end
        wait_for(1, 1'b0, 40, at);
        e = pop_exp();
        checks++;
        if (at !== e.val) begin
            errors++;
            $display("FAIL %s: got edge %0d want edge %0d", e.name, at, e.val);
        end
        at = (seq_done === 1'b1) ? edge_n : -1;
        e = pop_exp();
        checks++;
        if (at !== e.val) begin
            errors++;
            $display("FAIL %s: got edge %0d want edge %0d", e.name, at, e.val);
        end
    endtask

    // Relock from WAIT_LOCK and confirm the full stretch + gap sequence.
    task automatic relock_and_check(input string tag);
        int   at;
        exp_t e;
        pll_locked = 1'b1;
        edge_n     = -1;
        push_exp({tag, "_periph_fall"}, 1 + 1 + STRETCH);
        push_exp({tag, "_cpu_fall"}, 1 + 1 + STRETCH + GAP);
        wait_for(0, 1'b0, 60, at);
        e = pop_exp();
        checks++;
        if (at !== e.val) begin
            errors++;
            $display("FAIL %s: got edge %0d want edge %0d", e.name, at, e.val);
        end
        wait_for(1, 1'b0, 60, at);
        e = pop_exp();
        checks++;
        if (at !== e.val) begin
            errors++;
            $display("FAIL %s: got edge %0d want edge %0d", e.name, at, e.val);
        end
    endtask

    task automatic test_lock_loss();
        int   at;
        exp_t e;
        push_exp("ll_periph_rise", 2);
        push_exp("ll_loss_cnt", 1);
        pll_locked = 1'b0;
        edge_n     = -1;
        wait_for(0, 1'b1, 10, at);
        e = pop_exp();
        checks++;
        if (at !== e.val) begin
            errors++;
            $display("FAIL %s: got edge %0d want edge %0d", e.name, at, e.val);
        end
        checks++;
        if (cpu_reset !== 1'b1 || seq_done !== 1'b0) begin
            errors++;
            $display("FAIL ll_cpu_seq: got cpu=%b seq_done=%b want cpu=1 seq_done=0",
                     cpu_reset, seq_done);
        end
        e = pop_exp();
        checks++;
        if (int'(lock_loss_cnt) !== e.val) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", e.name, lock_loss_cnt, e.val);
        end
        while (edge_n < 4) step();
        relock_and_check("ll_relock");
    endtask

`ifdef RESET_SEQ_DEBOUNCE_EN
    task automatic test_bounce();
        int   at;
        int   bad;
        exp_t e;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            btn_reset = ~btn_reset;
            repeat (5) begin
                step();
                if (seq_done !== 1'b1) bad++;
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bounce_no_abort: got %0d non-RUN cycles want 0", bad);
        end
        btn_reset = 1'b1;
        edge_n    = -1;
        push_exp("btn_abort_edge", 2 + DEB);
        push_exp("btn_loss_cnt", 1);
        wait_for(0, 1'b1, 60, at);
        e = pop_exp();
        checks++;
        if (at !== e.val) begin
            errors++;
            $display("FAIL %s: got edge %0d want edge %0d", e.name, at, e.val);
        end
        e = pop_exp();
        checks++;
        if (int'(lock_loss_cnt) !== e.val) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", e.name, lock_loss_cnt, e.val);
        end
        bad = 0;
        repeat (40) begin
            step();
            if (periph_reset !== 1'b1 || cpu_reset !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL btn_hold_stays: got %0d released cycles want 0", bad);
        end
        btn_reset = 1'b0;
        edge_n    = -1;
        push_exp("btn_rel_periph_fall", 2 + DEB + STRETCH);
        push_exp("btn_rel_cpu_fall", 2 + DEB + STRETCH + GAP);
        wait_for(0, 1'b0, 80, at);
        e = pop_exp();
        checks++;
        if (at !== e.val) begin
            errors++;
            $display("FAIL %s: got edge %0d want edge %0d", e.name, at, e.val);
        end
        wait_for(1, 1'b0, 80, at);
        e = pop_exp();
        checks++;
        if (at !== e.val) begin
            errors++;
            $display("FAIL %s: got edge %0d want edge %0d", e.name, at, e.val);
        end
    endtask
`else
    task automatic test_bounce();
        int   at;
        exp_t e;
        btn_reset = 1'b1;
        edge_n    = -1;
        push_exp("pulse_abort_edge", 2);
        push_exp("pulse_loss_cnt", 1);
        push_exp("pulse_periph_fall", 3 + STRETCH);
        push_exp("pulse_cpu_fall", 3 + STRETCH + GAP);
        step();
        btn_reset = 1'b0;
        wait_for(0, 1'b1, 10, at);
        e = pop_exp();
        checks++;
        if (at !== e.val) begin
            errors++;
            $display("FAIL %s: got edge %0d want edge %0d", e.name, at, e.val);
        end
        e = pop_exp();
        checks++;
        if (int'(lock_loss_cnt) !== e.val) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", e.name, lock_loss_cnt, e.val);
        end
        wait_for(0, 1'b0, 40, at);
        e = pop_exp();
        checks++;
        if (at !== e.val) begin
            errors++;
            $display("FAIL %s: got edge %0d want edge %0d", e.name, at, e.val);
        end
        wait_for(1, 1'b0, 40, at);
        e = pop_exp();
        checks++;
        if (at !== e.val) begin
            errors++;
            $display("FAIL %s: got edge %0d want edge %0d", e.name, at, e.val);
        end
    endtask
`endif

    task automatic test_abort_stretch();
        int   at;
        int   bad;
        exp_t e;
        push_exp("as_loss_before", 2);
        push_exp("as_loss_after", 2);
        pll_locked = 1'b0;
        edge_n     = -1;
        wait_for(0, 1'b1, 10, at);
        e = pop_exp();
        checks++;
        if (int'(lock_loss_cnt) !== e.val) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", e.name, lock_loss_cnt, e.val);
        end
        while (edge_n < 4) step();
        // STRETCH is entered at edge 2, so lock_s reads 0 while cnt=5.
        pll_locked = 1'b1;
        edge_n     = -1;
        while (edge_n < 5) step();
        pll_locked = 1'b0;
        bad = 0;
        while (edge_n < 20) begin
            step();
            if (periph_reset !== 1'b1 || cpu_reset !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL as_periph_held: got %0d released cycles want 0", bad);
        end
        e = pop_exp();
        checks++;
        if (int'(lock_loss_cnt) !== e.val) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", e.name, lock_loss_cnt, e.val);
        end
        relock_and_check("as_relock");
    endtask

    task automatic test_saturation();
        int   at;
        int   model;
        exp_t e;
        model = 2;
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            wait_for(0, 1'b1, 10, at);
            model = (model < 255) ? model + 1 : 255;
            push_exp("sat_loss_cnt", model);
            e = pop_exp();
            checks++;
            if (int'(lock_loss_cnt) !== e.val) begin
                errors++;
                $display("FAIL %s[%0d]: got %0d want %0d", e.name, i, lock_loss_cnt, e.val);
            end
            pll_locked = 1'b1;
            wait_for(2, 1'b1, 30, at);
            checks++;
            if (at === -1) begin
                errors++;
                $display("FAIL sat_rerun[%0d]: got timeout want seq_done=1", i);
            end
        end
        push_exp("sat_final", 255);
        e = pop_exp();
        checks++;
        if (int'(lock_loss_cnt) !== e.val) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", e.name, lock_loss_cnt, e.val);
        end
    endtask

    task automatic test_async_reset();
        int at;
        pll_locked = 1'b0;
        wait_for(0, 1'b1, 10, at);
        pll_locked = 1'b1;
        edge_n     = -1;
        wait_for(0, 1'b0, 40, at);
        step();
        checks++;
        if (periph_reset !== 1'b0 || cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL ar_in_periph: got periph=%b cpu=%b want periph=0 cpu=1",
                     periph_reset, cpu_reset);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (periph_reset !== 1'b1 || cpu_reset !== 1'b1 || seq_done !== 1'b0) begin
            errors++;
            $display("FAIL ar_immediate: got periph=%b cpu=%b seq_done=%b want 1 1 0",
                     periph_reset, cpu_reset, seq_done);
        end
        checks++;
        if (lock_loss_cnt !== 8'd0) begin
            errors++;
            $display("FAIL ar_loss_cnt: got %0d want 0", lock_loss_cnt);
        end
        step();
        step();
        reset = 1'b0;
        relock_and_check("ar_restart");
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_lock_loss();
        test_bounce();
        test_abort_stretch();
        test_saturation();
        test_async_reset();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
